// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and widths for the instruction fetch stage.
//   pc_t          - 36-bit word address
//   inst_t        - 32-bit instruction word
//   fetch_entry_t - buffered {pc, inst} pair handed to decode
//   fetch_state_e - FETCH (normal) / FLUSH (draining stale responses)
package fetch_pkg;
    localparam int PC_W   = 36;
    localparam int INST_W = 32;

    typedef logic [PC_W-1:0]   pc_t;
    typedef logic [INST_W-1:0] inst_t;

    typedef struct packed {
        pc_t   pc;
        inst_t inst;
    } fetch_entry_t;

    typedef enum logic {
        FETCH = 1'b0,
        FLUSH = 1'b1
    } fetch_state_e;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry FIFO of fetch_entry_t between imem responses and decode.
// Ports:
//   clk, rst_n     - clock, synchronous active-low reset
//   push_i/data_i  - write an entry
//   pop_i          - consume the head (ignored when empty)
//   flush_i        - drop all entries; wins over push and pop in the same cycle
//   count_o        - number of valid entries (0..DEPTH)
//   head_o         - head entry, all zeros when empty
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  fetch_entry_t     data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [CNT_W-1:0] count_o,
    output fetch_entry_t     head_o
);
    localparam int PTR_W = $clog2(DEPTH);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_eff, pop_eff;

    assign push_eff = push_i && !flush_i;
    assign pop_eff  = pop_i && !flush_i && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap naturally
            if (push_eff) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_eff)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push_eff, pop_eff})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // storage needs no reset: the head is masked while empty
    always_ff @(posedge clk) begin
        if (push_eff) mem_q[wr_ptr_q] <= data_i;
    end

    assign count_o = count_q;
    assign head_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Owns the PC, issues in-order word
// requests to imem under a credit limit of DEPTH (outstanding + buffered),
// buffers responses with their PC and presents them to decode. A redirect
// reloads the PC, flushes the buffer and drops in-flight responses.
// Ports:
//   clk, rst_n                      - clock, synchronous active-low reset
//   imem_req_valid/ready/addr       - request channel (36-bit word address)
//   imem_resp_valid/data            - in-order responses, no backpressure
//   redirect_valid/redirect_pc      - new PC from the branch/jump decoder
//   inst_valid/ready/data/pc        - instruction handed to decode
//   perf_*_cnt                      - optional counters, present only when
//                                     FETCH_PERF_EN is defined
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [PC_W-1:0]   RESET_PC = 36'h0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [PC_W-1:0]   imem_req_addr,
    input  logic              imem_resp_valid,
    input  logic [INST_W-1:0] imem_resp_data,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst_data,
    output logic [PC_W-1:0]   inst_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_redirect_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);
    localparam int               CNT_W   = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    fetch_state_e     state_q, state_d;
    pc_t              pc_q, pc_d;
    logic [CNT_W-1:0] out_q, out_d;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W-1:0] credit_used;
    fetch_entry_t     fifo_head;
    fetch_entry_t     push_entry;
    logic             req_fire, resp_ok, push, pop, flush;

    // count + outstanding never exceeds DEPTH, so the sum fits CNT_W
    assign credit_used    = fifo_count + out_q;
    assign imem_req_valid = rst_n && (state_q == FETCH) &&
                            (credit_used < DEPTH_C) && !redirect_valid;
    assign imem_req_addr  = rst_n ? pc_q : RESET_PC;
    assign req_fire       = imem_req_valid && imem_req_ready;
    // a response with nothing tracked (e.g. from before reset) is ignored
    assign resp_ok        = imem_resp_valid && (out_q != '0);

    assign inst_valid = (fifo_count != '0);
    assign inst_data  = fifo_head.inst;
    assign inst_pc    = fifo_head.pc;
    assign pop        = inst_valid && inst_ready;

    // Requests in FETCH are consecutive since the last redirect, so the
    // oldest in-flight request is pc - outstanding (mod 2^36).
    assign push_entry.pc   = pc_q - PC_W'(out_q);
    assign push_entry.inst = imem_resp_data;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        push    = 1'b0;
        flush   = 1'b0;
        case ({req_fire, resp_ok})
            2'b10:   out_d = out_q + CNT_W'(1);
            2'b01:   out_d = out_q - CNT_W'(1);
            default: out_d = out_q;
        endcase
        if (req_fire) pc_d = pc_q + PC_W'(1);

        if (redirect_valid) begin
            // no request can fire this cycle, so out_d = outstanding - resp
            pc_d    = redirect_pc;
            flush   = 1'b1;
            state_d = (out_d != '0) ? FLUSH : FETCH;
        end else begin
            case (state_q)
                FETCH:   push = resp_ok;
                FLUSH:   if (out_d == '0) state_d = FETCH;
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            out_q   <= out_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .data_i  (push_entry),
        .pop_i   (pop),
        .flush_i (flush),
        .count_o (fifo_count),
        .head_o  (fifo_head)
    );

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_q, perf_redirect_q, perf_stall_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fetch_q    <= '0;
            perf_redirect_q <= '0;
            perf_stall_q    <= '0;
        end else begin
            perf_fetch_q    <= perf_fetch_q + 32'(push);
            perf_redirect_q <= perf_redirect_q + 32'(redirect_valid);
            perf_stall_q    <= perf_stall_q + 32'((state_q == FETCH) && !imem_req_valid);
        end
    end

    assign perf_fetch_cnt    = perf_fetch_q;
    assign perf_redirect_cnt = perf_redirect_q;
    assign perf_stall_cnt    = perf_stall_q;
`endif
endmodule
